demux_switch_sequencer: RTL and testbench

DEMUX_SWITCH_SEQUENCER -- requirements
Module: demux_switch_sequencer

---
 rtl/demux_seq_pkg.sv | 15 +
 rtl/pkt_outstanding_counter.sv | 60 ++++++
 rtl/demux_switch_sequencer.sv | 168 ++++++++++++++++
 tb/tb_demux_switch_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// Shared definitions for the demux switch sequencer: FSM state encoding and
// default sizing constants.
package demux_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLOCK  = 2'd1,
        S_DRAIN  = 2'd2,
        S_SWITCH = 2'd3
    } seq_state_e;

    localparam int DEF_OUTSTANDING_W = 8;
    localparam int DEF_DRAIN_TIMEOUT = 1024;

endpackage

// File: rtl/pkt_outstanding_counter.sv
// Counts packets between the demux input and its outputs: +1 per input tlast,
// -1 per output tlast, saturating at max and clamping at zero with an underflow flag.
module pkt_outstanding_counter #(
    parameter int M_COUNT = 2,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               inc,
    input  logic [M_COUNT-1:0] dec,
    input  logic               clear,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] count_next,
    output logic               underflow
);

    localparam int DEC_W = $clog2(M_COUNT + 1);
    localparam int EXT_W = ((COUNT_W > DEC_W) ? COUNT_W : DEC_W) + 1;
    localparam logic [EXT_W-1:0] COUNT_MAX = EXT_W'({COUNT_W{1'b1}});

    logic [COUNT_W-1:0] count_reg;
    logic [DEC_W-1:0]   dec_cnt;
    logic [EXT_W-1:0]   sum_ext;
    logic [EXT_W-1:0]   dec_ext;
    logic [EXT_W-1:0]   diff_ext;

    always_comb begin
        dec_cnt = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            dec_cnt = dec_cnt + DEC_W'(dec[i]);
        end
    end

    // Work one bit wider than either operand so both the saturation and the
    // underflow cases are visible before truncation.
    always_comb begin
        sum_ext    = EXT_W'(count_reg) + EXT_W'(inc);
        dec_ext    = EXT_W'(dec_cnt);
        diff_ext   = sum_ext - dec_ext;
        underflow  = 1'b0;
        count_next = diff_ext[COUNT_W-1:0];
        if (sum_ext < dec_ext) begin
            underflow  = 1'b1;
            count_next = '0;
        end else if (diff_ext > COUNT_MAX) begin
            count_next = COUNT_MAX[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/demux_switch_sequencer.sv
// Sequences a safe demux select change: block input at a packet boundary, drain
// in-flight packets, then switch. Optional statistics under SWITCH_SEQ_STATS_EN.
module demux_switch_sequencer
    import demux_seq_pkg::*;
#(
    parameter int M_COUNT       = 2,
    parameter int SELECT_SIZE   = $clog2(M_COUNT),
    parameter int OUTSTANDING_W = DEF_OUTSTANDING_W,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic                   axis_aclk,
    input  logic                   axis_areset,
    input  logic                   req_valid,
    input  logic [SELECT_SIZE-1:0] req_select,
    output logic                   req_ready,
    input  logic                   in_tvalid,
    input  logic                   in_tready,
    input  logic                   in_tlast,
    input  logic [M_COUNT-1:0]     out_tvalid,
    input  logic [M_COUNT-1:0]     out_tready,
    input  logic [M_COUNT-1:0]     out_tlast,
    output logic                   in_hold,
    output logic [SELECT_SIZE-1:0] select,
    output logic                   done,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   underflow_err,
    input  logic                   err_clear,
    output logic [15:0]            switch_count,
    output logic [15:0]            timeout_count
);

    localparam int TIMER_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'(S_IDLE);
    localparam logic [1:0] ST_BLOCK  = 2'(S_BLOCK);
    localparam logic [1:0] ST_DRAIN  = 2'(S_DRAIN);
    localparam logic [1:0] ST_SWITCH = 2'(S_SWITCH);

    logic [1:0]             state_reg, state_next;
    logic [SELECT_SIZE-1:0] latched_reg;
    logic [SELECT_SIZE-1:0] select_reg;
    logic                   done_reg;
    logic                   mid_pkt_reg;
    logic [TIMER_W-1:0]     timer_reg;
    logic                   timeout_err_reg;
    logic                   underflow_err_reg;
    logic                   timeout_hit;
    logic                   accept;
    logic                   in_hs;
    logic [M_COUNT-1:0]     dec_vec;
    logic [OUTSTANDING_W-1:0] count_next;
    logic [OUTSTANDING_W-1:0] count_unused;
    logic                   underflow;

    assign in_hs  = in_tvalid && in_tready;
    assign accept = req_valid && req_ready;

    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_dec
        assign dec_vec[gi] = out_tvalid[gi] & out_tready[gi] & out_tlast[gi];
    end

    pkt_outstanding_counter #(
        .M_COUNT (M_COUNT),
        .COUNT_W (OUTSTANDING_W)
    ) u_counter (
        .clk        (axis_aclk),
        .srst       (axis_areset),
        .inc        (in_hs && in_tlast),
        .dec        (dec_vec),
        .clear      (timeout_hit),
        .count      (count_unused),
        .count_next (count_next),
        .underflow  (underflow)
    );

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE:   if (req_valid) state_next = ST_BLOCK;
            ST_BLOCK:  if (!mid_pkt_reg) state_next = ST_DRAIN;
            ST_DRAIN: begin
                // A natural drain wins over a coincident timeout.
                if (count_next == '0) begin
                    state_next = ST_SWITCH;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next  = ST_SWITCH;
                    timeout_hit = 1'b1;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_reg         <= ST_IDLE;
            latched_reg       <= '0;
            select_reg        <= '0;
            done_reg          <= 1'b0;
            mid_pkt_reg       <= 1'b0;
            timer_reg         <= '0;
            timeout_err_reg   <= 1'b0;
            underflow_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_SWITCH);
            if (accept) begin
                latched_reg <= req_select;
            end
            if (state_reg == ST_SWITCH) begin
                select_reg <= latched_reg;
            end
            if (in_hs) begin
                mid_pkt_reg <= !in_tlast;
            end
            // Zero outside DRAIN, so the first DRAIN cycle always starts at 0.
            timer_reg <= (state_reg == ST_DRAIN) ? timer_reg + 1'b1 : '0;
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end else if (err_clear) begin
                timeout_err_reg <= 1'b0;
            end
            if (underflow) begin
                underflow_err_reg <= 1'b1;
            end else if (err_clear) begin
                underflow_err_reg <= 1'b0;
            end
        end
    end

    assign req_ready     = (state_reg == ST_IDLE);
    assign busy          = (state_reg != ST_IDLE);
    assign in_hold       = ((state_reg == ST_BLOCK) && !mid_pkt_reg) ||
                           (state_reg == ST_DRAIN) || (state_reg == ST_SWITCH);
    assign select        = select_reg;
    assign done          = done_reg;
    assign timeout_err   = timeout_err_reg;
    assign underflow_err = underflow_err_reg;

`ifdef SWITCH_SEQ_STATS_EN
    logic [15:0] switch_count_reg;
    logic [15:0] timeout_count_reg;

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            switch_count_reg  <= '0;
            timeout_count_reg <= '0;
        end else begin
            if (state_reg == ST_SWITCH) begin
                switch_count_reg <= switch_count_reg + 16'd1;
            end
            if (timeout_hit && (timeout_count_reg != 16'hFFFF)) begin
                timeout_count_reg <= timeout_count_reg + 16'd1;
            end
        end
    end

    assign switch_count  = switch_count_reg;
    assign timeout_count = timeout_count_reg;
`else
    assign switch_count  = 16'd0;
    assign timeout_count = 16'd0;
`endif

endmodule

// File: tb/tb_demux_switch_sequencer.sv
// Table-driven bench for demux_switch_sequencer with a scoreboard of pending switches.
module tb_demux_switch_sequencer;

    localparam int M_COUNT = 2;
    localparam int SEL_W   = 1;

    typedef struct {
        int sel;
        int beats;
        int n_down;
        int rc0;
        int rm0;
        int rc1;
        int rm1;
        int lat;
        int to;
    } vec_t;

    typedef struct {
        int sel;
        int to;
        int lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               srst;
    logic               req_valid;
    logic [SEL_W-1:0]   req_select;
    logic               req_ready;
    logic               in_tvalid, in_tready, in_tlast;
    logic [M_COUNT-1:0] out_tvalid, out_tready, out_tlast;
    logic               in_hold;
    logic [SEL_W-1:0]   select;
    logic               done, busy, timeout_err, underflow_err;
    logic               err_clear;
    logic [15:0]        switch_count, timeout_count;

    int   total = 0;
    int   bad   = 0;
    int   sw_model = 0;
    int   to_model = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    demux_switch_sequencer #(
        .M_COUNT       (M_COUNT),
        .SELECT_SIZE   (SEL_W),
        .OUTSTANDING_W (8),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .axis_aclk     (clk),
        .axis_areset   (srst),
        .req_valid     (req_valid),
        .req_select    (req_select),
        .req_ready     (req_ready),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .in_tlast      (in_tlast),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .out_tlast     (out_tlast),
        .in_hold       (in_hold),
        .select        (select),
        .done          (done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .underflow_err (underflow_err),
        .err_clear     (err_clear),
        .switch_count  (switch_count),
        .timeout_count (timeout_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_drive();
        in_tvalid = 1'b0; in_tready = 1'b0; in_tlast = 1'b0;
        out_tvalid = '0;  out_tready = '0;  out_tlast = '0;
    endtask

    task automatic check_stats(input string tag);
`ifdef SWITCH_SEQ_STATS_EN
        chk({tag, "_switch_count"}, switch_count, sw_model);
        chk({tag, "_timeout_count"}, timeout_count, to_model);
`else
        chk({tag, "_switch_count"}, switch_count, 0);
        chk({tag, "_timeout_count"}, timeout_count, 0);
`endif
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int   c;
        int   prof_bad_c;
        bit   seen;
        exp_t e;
        logic [M_COUNT-1:0] m;
        for (int k = 0; k < v.n_down; k++) begin
            in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
            tick();
        end
        if (v.beats > 0) begin
            in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b0;
            tick();
        end
        clear_drive();
        chk("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_select = SEL_W'(v.sel);
        sb_q.push_back('{v.sel, v.to, v.lat});
        tick();
        req_valid = 1'b0;
        c = 1;
        seen = 1'b0;
        prof_bad_c = -1;
        while (!seen && c <= 60) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (prof_bad_c < 0 &&
                    (in_hold !== ((c >= v.beats + 1) && (c < v.lat)) ||
                     busy !== (c < v.lat) || req_ready !== (c >= v.lat))) begin
                    prof_bad_c = c;
                end
                if (c <= v.beats) begin
                    in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = (c == v.beats);
                end
                m = '0;
                if (c == v.rc0) m = m | M_COUNT'(v.rm0);
                if (c == v.rc1) m = m | M_COUNT'(v.rm1);
                out_tvalid = m; out_tready = m; out_tlast = m;
                tick();
                clear_drive();
                c++;
            end
        end
        chk("hold_busy_profile_bad_cycle", prof_bad_c, -1);
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_wait case %0d: no done within 60 cycles, want cycle %0d", idx, v.lat);
        end else if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard case %0d: done with empty queue, want pending entry", idx);
        end else begin
            e = sb_q.pop_front();
            chk("latency", c, e.lat);
            chk("select", select, e.sel);
            chk("timeout_err", timeout_err, e.to);
            sw_model++;
            if (e.to != 0 && to_model < 65535) to_model++;
        end
        tick();
        chk("done_pulse_end", done, 0);
        chk("busy_after", busy, 0);
        if (v.to != 0) begin
            err_clear = 1'b1;
            tick();
            err_clear = 1'b0;
            chk("timeout_err_cleared", timeout_err, 0);
        end
        $display("case %0d: sel=%0d beats=%0d down=%0d lat=%0d to=%0d select_now=%0d",
                 idx, v.sel, v.beats, v.n_down, c, timeout_err, select);
    endtask

    initial begin
        int  idle_bad;
        //          sel beats down rc0 rm0 rc1 rm1 lat to
        vecs[0] = '{1,  0,    0,  -1,  0,  -1,  0,  4, 0};
        vecs[1] = '{1,  0,    0,  -1,  0,  -1,  0,  4, 0};
        vecs[2] = '{0,  3,    0,   7,  1,  -1,  0,  9, 0};
        vecs[3] = '{1,  0,    2,   5,  1,   9,  2, 11, 0};
        vecs[4] = '{0,  0,    1,  -1,  0,  -1,  0, 19, 1};
        vecs[5] = '{1,  0,    0,  -1,  0,  -1,  0,  4, 0};
        vecs[6] = '{1,  1,    1,   4,  3,  -1,  0,  6, 0};
        vecs[7] = '{1,  0,    0,  -1,  0,  -1,  0,  4, 0};

        srst = 1'b1;
        req_valid = 1'b0;
        req_select = '0;
        err_clear = 1'b0;
        clear_drive();
        repeat (3) tick();
        srst = 1'b0;
        chk("rst_select", select, 0);
        chk("rst_in_hold", in_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_underflow_err", underflow_err, 0);
        chk("rst_req_ready", req_ready, 1);
        check_stats("rst");
        tick();

        for (int i = 0; i < 7; i++) begin
            run_case(i, vecs[i]);
        end
        check_stats("after_cases");

        // Output tlast with nothing outstanding
        out_tvalid = 2'b10; out_tready = 2'b10; out_tlast = 2'b10;
        tick();
        clear_drive();
        chk("underflow_set", underflow_err, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("underflow_cleared", underflow_err, 0);
        out_tvalid = 2'b01; out_tready = 2'b01; out_tlast = 2'b01;
        err_clear = 1'b1;
        tick();
        clear_drive();
        err_clear = 1'b0;
        chk("underflow_set_beats_clear", underflow_err, 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("underflow_cleared_again", underflow_err, 0);

        // Reset during a stalled DRAIN abandons the pending request
        in_tvalid = 1'b1; in_tready = 1'b1; in_tlast = 1'b1;
        tick();
        clear_drive();
        req_valid = 1'b1;
        req_select = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("drain_in_hold", in_hold, 1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        sb_q.delete();
        sw_model = 0;
        to_model = 0;
        chk("mid_rst_select", select, 0);
        chk("mid_rst_in_hold", in_hold, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0 || select !== 1'b0) idle_bad++;
        end
        chk("abandoned_idle_bad_cycles", idle_bad, 0);

        run_case(7, vecs[7]);
        check_stats("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
